// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory handshake,
// next-PC mux candidates and the IF/ID pipeline register with stall/flush.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target,
  output logic [31:0] j_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] hold;
  logic [31:0] redir;
  logic [31:0] br_offset;

  assign imem_addr = pc;
  assign imem_req  = !rst && (state != S_HOLD);
  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
  assign br_target = if_id_pc4 + br_offset;
  assign j_target  = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= PC_RESET;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      hold        <= 32'd0;
      redir       <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (flush && imem_ack) begin
            pc          <= next_pc;
            if_id_valid <= 1'b0;
          end else if (flush) begin
            // request is still in flight; remember where to go once it retires
            redir       <= next_pc;
            if_id_valid <= 1'b0;
            state       <= S_DROP;
          end else if (imem_ack && !stall) begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pc          <= next_pc;
          end else if (imem_ack) begin
            hold  <= imem_rdata;
            state <= S_HOLD;
          end else if (!stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (flush) begin
            if_id_valid <= 1'b0;
            pc          <= next_pc;
            state       <= S_REQ;
          end else if (!stall) begin
            if_id_instr <= hold;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pc          <= next_pc;
            state       <= S_REQ;
          end
        end
        S_DROP: begin
          if_id_valid <= 1'b0;
          if (imem_ack) begin
            pc    <= flush ? next_pc : redir;
            state <= S_REQ;
          end else if (flush) begin
            redir <= next_pc;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed-vector bench for if_fetch_stage with hand-computed expected values.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks   = 0;
  int failures = 0;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc    (next_pc),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .br_target  (br_target),
    .j_target   (j_target),
    .if_id_instr(if_id_instr),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [31:0] rd, input logic st,
                       input logic fl, input logic [31:0] np);
    imem_ack   = a;
    imem_rdata = rd;
    stall      = st;
    flush      = fl;
    next_pc    = np;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check("req_in_reset", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    // reset state
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, 32'h0);

    // zero-wait stream
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0, 32'h0000_3004);
    tick();
    check("s1_pc", pc, 32'h0000_3004);
    check("s1_pc4", if_id_pc4, 32'h0000_3004);
    check("s1_instr", if_id_instr, 32'h2008_0001);
    check("s1_valid", {31'd0, if_id_valid}, 32'd1);
    drive(1'b1, 32'h1000_FFFF, 1'b0, 1'b0, 32'h0000_3008);
    tick();
    check("s2_pc", pc, 32'h0000_3008);
    check("s2_pc4", if_id_pc4, 32'h0000_3008);
    check("br_target", br_target, 32'h0000_3004);

    // stall on the ack cycle for three clocks
    drive(1'b1, 32'h0800_0010, 1'b1, 1'b0, 32'h0000_300C);
    tick();
    check("h1_req", {31'd0, imem_req}, 32'd0);
    check("h1_instr", if_id_instr, 32'h1000_FFFF);
    check("h1_pc", pc, 32'h0000_3008);
    drive(1'b0, 32'hDEAD_0000, 1'b1, 1'b0, 32'h0000_9999);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("h_req", {31'd0, imem_req}, 32'd0);
      check("h_instr", if_id_instr, 32'h1000_FFFF);
    end
    drive(1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0000_300C);
    tick();
    check("rel_instr", if_id_instr, 32'h0800_0010);
    check("rel_pc4", if_id_pc4, 32'h0000_300C);
    check("rel_valid", {31'd0, if_id_valid}, 32'd1);
    check("rel_pc", pc, 32'h0000_300C);
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("j_small", j_target, 32'h0000_0040);

    // flush and ack together
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_3004);
    tick();
    check("fa_valid", {31'd0, if_id_valid}, 32'd0);
    check("fa_pc", pc, 32'h0000_3004);
    check("fa_instr", if_id_instr, 32'h0800_0010);

    // redirect mid-wait, second flush wins, ack three cycles after the first flush
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3F00);
    tick();
    check("d0_addr", imem_addr, 32'h0000_3004);
    check("d0_req", {31'd0, imem_req}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4000);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_5555);
    tick();
    check("d2_addr", imem_addr, 32'h0000_3004);
    check("d2_valid", {31'd0, if_id_valid}, 32'd0);
    drive(1'b1, 32'hBADB_AD00, 1'b0, 1'b0, 32'h0000_5555);
    tick();
    check("d3_pc", pc, 32'h0000_4000);
    check("d3_instr", if_id_instr, 32'h0800_0010);
    check("d3_valid", {31'd0, if_id_valid}, 32'd0);

    // bubble inserts NOP
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_7777);
    tick();
    check("bub_instr", if_id_instr, 32'h0);
    check("bub_pc", pc, 32'h0000_4000);

    // jump target and wrap-around
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'hEFFF_FFFC);
    tick();
    drive(1'b1, 32'h0800_0010, 1'b0, 1'b0, 32'hFFFF_FFFC);
    tick();
    check("j_pc4", if_id_pc4, 32'hF000_0000);
    check("j_target", j_target, 32'hF000_0040);
    check("wrap_pc4", pc_plus4, 32'h0000_0000);
    drive(1'b1, 32'h0000_0123, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    check("wrap_ifpc4", if_id_pc4, 32'h0000_0000);
    check("wrap_pc", pc, 32'h0000_0000);

    // flush while holding a buffered instruction
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0004);
    tick();
    check("hf0_req", {31'd0, imem_req}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3100);
    tick();
    check("hf_pc", pc, 32'h0000_3100);
    check("hf_valid", {31'd0, if_id_valid}, 32'd0);
    check("hf_instr", if_id_instr, 32'h0000_0123);
    check("hf_req", {31'd0, imem_req}, 32'd1);

    // asynchronous reset mid-fetch, ack during reset ignored
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3200);
    #2;
    rst = 1'b1;
    #1;
    check("ar_pc", pc, 32'h0000_3000);
    check("ar_req", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_3200);
    tick();
    check("ar_instr", if_id_instr, 32'h0);
    check("ar_pc2", pc, 32'h0000_3000);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    check("ar_rel_req", {31'd0, imem_req}, 32'd1);
    check("ar_rel_valid", {31'd0, if_id_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
